// File: rtl/encoder_n_iter_pkg.sv
// Shared types and helpers for the iterating set-bit encoder.
package encoder_pkg;

    typedef enum logic {IDLE, EMIT} enc_state_t;

    // Index width for an n-bit vector; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/encoder_n_iter_if.sv
// Input vector stream and output index stream of the iterating encoder.
interface encoder_n_iter_if
    import encoder_pkg::*;
#(
    parameter int unsigned N = 16
);
    localparam int unsigned IDX_W = idx_width(N);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic             out_zero;

    // Drives vectors in, consumes index beats.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_last, out_zero
    );

    // The encoder itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_last, out_zero
    );

endinterface

// File: rtl/encoder_n_iter_pick_first.sv
// Combinational find-first-set in a fixed priority direction.
module pick_first
    import encoder_pkg::*;
#(
    parameter int unsigned N         = 16,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned IDX_W    = idx_width(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic [N-1:0]     onehot
);

    // Scan in priority order; the first set bit wins and blocks the rest.
    always_comb begin
        idx    = '0;
        any    = 1'b0;
        onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && vec[MSB_FIRST ? (N - 1 - i) : i]) begin
                any = 1'b1;
                idx = IDX_W'(MSB_FIRST ? (N - 1 - i) : i);
                onehot[MSB_FIRST ? (N - 1 - i) : i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_n_iter.sv
// Accepts an N-bit vector and emits the index of each set bit, one beat per cycle.
module encoder_n_iter
    import encoder_pkg::*;
#(
    parameter int unsigned N         = 16,
    parameter bit          MSB_FIRST = 1'b0
) (
    input logic              clk,
    input logic              rst,
    encoder_n_iter_if.slave  bus
);

    localparam int unsigned IDX_W = idx_width(N);

    enc_state_t       state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [N-1:0]     pick_onehot;
    logic             single;
    logic             emit;
    logic             out_fire;

    pick_first #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_pick (
        .vec    (pending_q),
        .idx    (pick_idx),
        .any    (pick_any),
        .onehot (pick_onehot)
    );

    // Zero or one bit left means the current beat is the last (zero case included).
    assign single   = (pending_q & (pending_q - N'(1))) == '0;
    assign emit     = (state_q == EMIT);
    assign out_fire = emit && bus.out_ready;

    assign bus.out_valid = emit;
    assign bus.out_index = emit ? pick_idx : '0;
    assign bus.out_last  = emit && single;
    assign bus.out_zero  = emit && !pick_any;
    // out_ready feeds in_ready combinationally so back-to-back vectors need no bubble.
    assign bus.in_ready  = !emit || (out_fire && single);

    // Next-state and pending update for capture, bit clearing and hand-off.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    pending_d = bus.in_data;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (out_fire) begin
                    pending_d = pending_q & ~pick_onehot;
                    if (single) begin
                        if (bus.in_valid) begin
                            pending_d = bus.in_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // State and pending registers with synchronous reset dropping any in-flight vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_encoder_n_iter.sv
// Bench for encoder_n_iter: N=16 LSB-first and N=12 MSB-first instances, scoreboard queue.
module tb_encoder_n_iter;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
        logic       zero;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bit          sel = 1'b0;       // 0: 16-bit LSB-first DUT, 1: 12-bit MSB-first DUT
    logic        in_valid_v = 1'b0;
    logic [15:0] in_data_v = '0;
    logic        out_ready_v = 1'b0;
    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];

    encoder_n_iter_if #(.N(16)) if16 ();
    encoder_n_iter_if #(.N(12)) if12 ();

    assign if16.in_valid  = !sel && in_valid_v;
    assign if16.in_data   = in_data_v;
    assign if16.out_ready = !sel && out_ready_v;
    assign if12.in_valid  = sel && in_valid_v;
    assign if12.in_data   = in_data_v[11:0];
    assign if12.out_ready = sel && out_ready_v;

    encoder_n_iter #(.N(16), .MSB_FIRST(1'b0)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    encoder_n_iter #(.N(12), .MSB_FIRST(1'b1)) u_dut12 (
        .clk (clk),
        .rst (rst),
        .bus (if12)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats for one accepted vector, in the selected DUT's priority order.
    task automatic push_vec(input logic [15:0] vec);
        int    n;
        int    total;
        int    cnt;
        int    i;
        beat_t b;
        n     = sel ? 12 : 16;
        total = 0;
        cnt   = 0;
        for (int k = 0; k < n; k++) total += vec[k];
        if (total == 0) begin
            b = '{idx: 4'd0, last: 1'b1, zero: 1'b1};
            exp_q.push_back(b);
        end else begin
            for (int k = 0; k < n; k++) begin
                i = sel ? (n - 1 - k) : k;
                if (vec[i]) begin
                    cnt++;
                    b = '{idx: 4'(i), last: (cnt == total), zero: 1'b0};
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // One clock: sample at negedge, score handshakes, then advance past posedge.
    task automatic cycle(output bit acc);
        logic       ov, ir, ol, oz;
        logic [3:0] oi;
        logic       exp_ir;
        @(negedge clk);
        ov = sel ? if12.out_valid : if16.out_valid;
        ir = sel ? if12.in_ready  : if16.in_ready;
        ol = sel ? if12.out_last  : if16.out_last;
        oz = sel ? if12.out_zero  : if16.out_zero;
        oi = sel ? if12.out_index : if16.out_index;
        acc = 1'b0;
        if (rst) begin
            exp_q.delete();
        end else begin
            chk("out_valid", 32'(ov), 32'(exp_q.size() != 0));
            exp_ir = (exp_q.size() == 0) ? 1'b1 : (out_ready_v && exp_q[0].last);
            chk("in_ready", 32'(ir), 32'(exp_ir));
            if (exp_q.size() != 0) begin
                chk("out_index", 32'(oi), 32'(exp_q[0].idx));
                chk("out_last", 32'(ol), 32'(exp_q[0].last));
                chk("out_zero", 32'(oz), 32'(exp_q[0].zero));
                if (sel) chk("index_range", 32'(oi < 4'd12), 32'd1);
                if (out_ready_v) void'(exp_q.pop_front());
            end
            acc = in_valid_v && ir;
            if (acc) push_vec(in_data_v);
        end
        @(posedge clk);
        #1;
    endtask

    // Present a vector and hold in_valid until it is taken; caller lowers in_valid.
    task automatic send(input logic [15:0] vec);
        bit acc;
        in_valid_v = 1'b1;
        in_data_v  = vec;
        acc        = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) cycle(acc);
        chk("send_accepted", 32'(acc), 32'd1);
    endtask

    // Run until every expected beat is consumed; mode 0 ready, 1 toggled, 2 random.
    task automatic drain(input int mode);
        bit acc;
        in_valid_v = 1'b0;
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
            case (mode)
                0:       out_ready_v = 1'b1;
                1:       out_ready_v = k[0];
                default: out_ready_v = 1'($urandom_range(0, 1));
            endcase
            cycle(acc);
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        out_ready_v = 1'b1;
        cycle(acc);
    endtask

    initial begin
        bit acc;
        logic [15:0] rv;

        // Reset and reset-state values on both instances.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst16_out_valid", 32'(if16.out_valid), 32'd0);
        chk("rst16_out_index", 32'(if16.out_index), 32'd0);
        chk("rst16_out_last", 32'(if16.out_last), 32'd0);
        chk("rst16_out_zero", 32'(if16.out_zero), 32'd0);
        chk("rst16_in_ready", 32'(if16.in_ready), 32'd1);
        chk("rst12_out_valid", 32'(if12.out_valid), 32'd0);
        chk("rst12_in_ready", 32'(if12.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Two-bit vector, consumer always ready.
        out_ready_v = 1'b1;
        send(16'h8001);
        in_valid_v = 1'b0;
        drain(0);

        // All-zero vector yields a single zero beat.
        send(16'h0000);
        in_valid_v = 1'b0;
        drain(0);

        // All bits set under toggling backpressure.
        send(16'hFFFF);
        in_valid_v = 1'b0;
        drain(1);

        // Back-to-back vectors with in_valid held throughout.
        out_ready_v = 1'b1;
        send(16'h0006);
        send(16'h0010);
        in_valid_v = 1'b0;
        drain(0);

        // Reset after the second beat drops the rest of the vector.
        send(16'h00FF);
        in_valid_v = 1'b0;
        cycle(acc);
        cycle(acc);
        out_ready_v = 1'b0;
        rst = 1'b1;
        cycle(acc);
        rst = 1'b0;
        out_ready_v = 1'b1;
        cycle(acc);
        send(16'h0100);
        in_valid_v = 1'b0;
        drain(0);

        // Random vectors on the 16-bit instance with random backpressure.
        for (int t = 0; t < 10; t++) begin
            rv = 16'($urandom);
            if (t == 3) rv = 16'h0000;
            send(rv);
            in_valid_v = 1'b0;
            drain(2);
        end

        // MSB-first, N=12.
        sel = 1'b1;
        out_ready_v = 1'b1;
        send(16'h0801);
        in_valid_v = 1'b0;
        drain(0);
        send(16'h0FFF);
        in_valid_v = 1'b0;
        drain(1);
        for (int t = 0; t < 15; t++) begin
            rv = 16'($urandom_range(0, 4095));
            out_ready_v = 1'($urandom_range(0, 1));
            send(rv);
            in_valid_v = 1'b0;
            drain(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
